// File: rtl/if_id_skid.sv
// IF/ID skid buffer: 2-entry in-order FIFO of {PC+2, instruction, error} between fetch and decode.
// Optional define IF_ID_SKID_BYPASS_EN lets an empty buffer forward fetch outputs combinationally.
module if_id_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        validIn,
   input  logic [15:0] PCAdd2In,
   input  logic [15:0] InstIn,
   input  logic        errIn,
   output logic        readyOut,
   input  logic        readyIn,
   input  logic        flush,
   output logic        validOut,
   output logic [15:0] PCAdd2Out,
   output logic [15:0] InstOut,
   output logic        errOut
);

   localparam logic [15:0] NopInst = 16'h0800;

   logic [1:0]  count_q, count_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        ready_q, ready_d;
   logic [15:0] pc_q   [2];
   logic [15:0] inst_q [2];
   logic        err_q  [2];

   logic        empty;
   logic        push, pop;
   logic        consume;
   logic        store, advance;
   logic        head_valid;
   logic [15:0] head_pc, head_inst;
   logic        head_err;

   assign empty = (count_q == 2'd0);

   // Ready is a flop, so it never depends on readyIn and stays low until the first edge after reset.
   assign readyOut = ready_q;

   always_comb begin
      head_valid = 1'b0;
      head_pc    = 16'h0000;
      head_inst  = NopInst;
      head_err   = 1'b0;
      if (!empty) begin
         head_valid = 1'b1;
         head_pc    = pc_q[rd_ptr_q];
         head_inst  = inst_q[rd_ptr_q];
         head_err   = err_q[rd_ptr_q];
      end
`ifdef IF_ID_SKID_BYPASS_EN
      else if (validIn && !flush && !rst) begin
         head_valid = 1'b1;
         head_pc    = PCAdd2In;
         head_inst  = InstIn;
         head_err   = errIn;
      end
`endif
   end

   assign validOut  = head_valid;
   assign PCAdd2Out = head_pc;
   assign InstOut   = head_inst;
   assign errOut    = head_err & head_valid & ~rst;

   assign push = validIn & readyOut & ~flush;
   assign pop  = head_valid & readyIn;

`ifdef IF_ID_SKID_BYPASS_EN
   // An entry forwarded through an empty buffer and taken by decode the same cycle is never stored.
   assign consume = empty & push & pop;
`else
   assign consume = 1'b0;
`endif

   assign store   = push & ~consume;
   assign advance = pop & ~consume;

   always_comb begin
      count_d  = count_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
         count_d  = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end else begin
         if (store) begin
            wr_ptr_d = ~wr_ptr_q;
         end
         if (advance) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({store, advance})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      ready_d = (count_d != 2'd2);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            pc_q[i]   <= 16'h0000;
            inst_q[i] <= NopInst;
            err_q[i]  <= 1'b0;
         end
      end else if (store && !flush) begin
         pc_q[wr_ptr_q]   <= PCAdd2In;
         inst_q[wr_ptr_q] <= InstIn;
         err_q[wr_ptr_q]  <= errIn;
      end
   end

`ifndef SYNTHESIS
   count_in_range : assert property (@(posedge clk) disable iff (rst) count_q <= 2'd2);
   no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      (count_q == 2'd2) |-> !readyOut);
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed bench for if_id_skid: vector table for streaming/backpressure/flush/error,
// plus hand sequences for async reset and (when IF_ID_SKID_BYPASS_EN is defined) bypass.
module tb_if_id_skid;

   logic        clk = 1'b0;
   logic        rst;
   logic        validIn;
   logic [15:0] PCAdd2In;
   logic [15:0] InstIn;
   logic        errIn;
   logic        readyOut;
   logic        readyIn;
   logic        flush;
   logic        validOut;
   logic [15:0] PCAdd2Out;
   logic [15:0] InstOut;
   logic        errOut;

   int checks = 0;
   int errors = 0;

   if_id_skid dut (
      .clk       (clk),
      .rst       (rst),
      .validIn   (validIn),
      .PCAdd2In  (PCAdd2In),
      .InstIn    (InstIn),
      .errIn     (errIn),
      .readyOut  (readyOut),
      .readyIn   (readyIn),
      .flush     (flush),
      .validOut  (validOut),
      .PCAdd2Out (PCAdd2Out),
      .InstOut   (InstOut),
      .errOut    (errOut)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic        vi;
      logic [15:0] inst;
      logic        ei;
      logic        ri;
      logic        fl;
      logic        ev;
      logic [15:0] einst;
      logic        ee;
      logic        er;
   } vec_t;

   function automatic vec_t mk(input logic vi, input logic [15:0] inst, input logic ei,
                               input logic ri, input logic fl, input logic ev,
                               input logic [15:0] einst, input logic ee, input logic er);
      vec_t v;
      v.vi = vi; v.inst = inst; v.ei = ei; v.ri = ri; v.fl = fl;
      v.ev = ev; v.einst = einst; v.ee = ee; v.er = er;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vi, input logic [15:0] inst, input logic ei,
                        input logic ri, input logic fl);
      validIn  = vi;
      InstIn   = inst;
      PCAdd2In = inst + 16'd2;
      errIn    = ei;
      readyIn  = ri;
      flush    = fl;
   endtask

   task automatic check_head(input string tag, input logic ev, input logic [15:0] einst,
                             input logic ee, input logic er);
      check({tag, " validOut"},  {15'd0, validOut}, {15'd0, ev});
      check({tag, " InstOut"},   InstOut, einst);
      check({tag, " PCAdd2Out"}, PCAdd2Out, ev ? einst + 16'd2 : 16'h0000);
      check({tag, " errOut"},    {15'd0, errOut}, {15'd0, ee});
      check({tag, " readyOut"},  {15'd0, readyOut}, {15'd0, er});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[24];

      vecs[0]  = mk(1, 16'h1111, 0, 1, 0, 0, 16'h0800, 0, 1);
      vecs[1]  = mk(1, 16'h2222, 0, 1, 0, 1, 16'h1111, 0, 1);
      vecs[2]  = mk(1, 16'h3333, 0, 1, 0, 1, 16'h2222, 0, 1);
      vecs[3]  = mk(1, 16'h4444, 0, 1, 0, 1, 16'h3333, 0, 1);
      vecs[4]  = mk(0, 16'h0000, 0, 1, 0, 1, 16'h4444, 0, 1);
      vecs[5]  = mk(0, 16'h0000, 0, 0, 0, 0, 16'h0800, 0, 1);
      vecs[6]  = mk(1, 16'hA000, 0, 0, 0, 0, 16'h0800, 0, 1);
      vecs[7]  = mk(1, 16'hA001, 0, 0, 0, 1, 16'hA000, 0, 1);
      vecs[8]  = mk(1, 16'hA002, 0, 0, 0, 1, 16'hA000, 0, 0);
      vecs[9]  = mk(0, 16'h0000, 0, 1, 0, 1, 16'hA000, 0, 0);
      vecs[10] = mk(0, 16'h0000, 0, 1, 0, 1, 16'hA001, 0, 1);
      vecs[11] = mk(0, 16'h0000, 0, 1, 0, 0, 16'h0800, 0, 1);
      vecs[12] = mk(1, 16'hB100, 0, 0, 0, 0, 16'h0800, 0, 1);
      vecs[13] = mk(1, 16'hB101, 0, 0, 0, 1, 16'hB100, 0, 1);
      vecs[14] = mk(1, 16'hB000, 0, 0, 1, 1, 16'hB100, 0, 0);
      vecs[15] = mk(0, 16'h0000, 0, 0, 0, 0, 16'h0800, 0, 1);
      vecs[16] = mk(1, 16'hC000, 1, 0, 0, 0, 16'h0800, 0, 1);
      vecs[17] = mk(1, 16'hC001, 0, 0, 0, 1, 16'hC000, 1, 1);
      vecs[18] = mk(0, 16'h0000, 0, 1, 0, 1, 16'hC000, 1, 0);
      vecs[19] = mk(0, 16'h0000, 0, 1, 0, 1, 16'hC001, 0, 1);
      vecs[20] = mk(0, 16'h0000, 0, 1, 0, 0, 16'h0800, 0, 1);
      vecs[21] = mk(1, 16'hE000, 0, 0, 0, 0, 16'h0800, 0, 1);
      vecs[22] = mk(1, 16'hE001, 0, 1, 1, 1, 16'hE000, 0, 1);
      vecs[23] = mk(0, 16'h0000, 0, 0, 0, 0, 16'h0800, 0, 1);

      rst = 1'b1;
      drive(0, 16'h0000, 0, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_head("reset_held", 0, 16'h0800, 0, 0);
      rst = 1'b0;
      #1;
      check("release readyOut", {15'd0, readyOut}, 16'h0000);

`ifndef IF_ID_SKID_BYPASS_EN
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         drive(vecs[i].vi, vecs[i].inst, vecs[i].ei, vecs[i].ri, vecs[i].fl);
         #1;
         check_head($sformatf("vec%0d", i), vecs[i].ev, vecs[i].einst, vecs[i].ee, vecs[i].er);
      end
`else
      @(negedge clk);
      drive(1, 16'hD000, 0, 1, 0);
      #1;
      check_head("byp_same_cycle", 1, 16'hD000, 0, 1);
      @(negedge clk);
      drive(0, 16'h0000, 0, 1, 0);
      #1;
      check_head("byp_not_stored", 0, 16'h0800, 0, 1);
      drive(1, 16'hD100, 0, 1, 1);
      #1;
      check_head("byp_flush", 0, 16'h0800, 0, 1);
      @(negedge clk);
      drive(1, 16'hD200, 1, 0, 0);
      #1;
      check_head("byp_fwd_err", 1, 16'hD200, 1, 1);
      @(negedge clk);
      drive(0, 16'h0000, 0, 1, 0);
      #1;
      check_head("byp_stored", 1, 16'hD200, 1, 1);
      @(negedge clk);
      #1;
      check_head("byp_drained", 0, 16'h0800, 0, 1);
`endif

      // Async reset pulsed between edges with the buffer full.
      @(negedge clk);
      drive(1, 16'hF000, 0, 0, 0);
      @(negedge clk);
      drive(1, 16'hF001, 0, 0, 0);
      @(negedge clk);
      drive(0, 16'h0000, 0, 0, 0);
      #1;
      check_head("pre_rst_full", 1, 16'hF000, 0, 0);
      #2;
      rst = 1'b1;
      #2;
      check_head("rst_async", 0, 16'h0800, 0, 0);
      #2;
      rst = 1'b0;
      #2;
      check_head("rst_released", 0, 16'h0800, 0, 0);
      @(posedge clk);
      #1;
      check_head("rst_after_edge", 0, 16'h0800, 0, 1);

      @(negedge clk);
      drive(1, 16'hF100, 0, 0, 0);
      @(negedge clk);
      drive(0, 16'h0000, 0, 1, 0);
      #1;
      check_head("post_rst_push", 1, 16'hF100, 0, 1);
      @(negedge clk);
      drive(0, 16'h0000, 0, 0, 0);
      #1;
      check_head("post_rst_empty", 0, 16'h0800, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
